// File: rtl/pe_fc_vec.sv
// Multi-lane fully-connected PE: stationary weights, 3-stage MAC pipeline,
// pass/accumulate group modes, ACC_W saturation and optional ReLU.
module pe_fc_vec #(
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 32,
  parameter int LANES    = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       write_kernel,
  input  logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] kernel_addr,
  input  logic [WEIGHT_W-1:0]                        kernel_data,
  input  logic                                       in_valid,
  input  logic [LANES*DATA_W-1:0]                    ifmap_in,
  input  logic [ACC_W-1:0]                           partial_sum_in,
  input  logic                                       acc_mode,
  input  logic                                       in_last,
  input  logic                                       relu_en,
  output logic                                       out_valid,
  output logic [ACC_W-1:0]                           output_sum,
  output logic                                       out_sat
);

  localparam int PW = DATA_W + WEIGHT_W;
  localparam int XW = (PW > ACC_W) ? PW : ACC_W;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int SW = ACC_W + LW + 2;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [XW-1:0]    MAX_X   = XW'(ACC_MAX);
  localparam logic signed [XW-1:0]    MIN_X   = XW'(ACC_MIN);
  localparam logic signed [SW-1:0]    MAX_S   = SW'(ACC_MAX);
  localparam logic signed [SW-1:0]    MIN_S   = SW'(ACC_MIN);

  typedef enum logic {IDLE, ACCUM} state_t;

  logic signed [WEIGHT_W-1:0] weight [LANES];

  logic                    s1_valid;
  logic [LANES*DATA_W-1:0] s1_ifmap;
  logic [ACC_W-1:0]        s1_psum;
  logic                    s1_mode;
  logic                    s1_last;
  logic                    s1_relu;

  logic signed [ACC_W-1:0] prod_c [LANES];
  logic [LANES-1:0]        lane_hi;
  logic [LANES-1:0]        lane_lo;
  logic                    psat_c;

  logic                    s2_valid;
  logic signed [ACC_W-1:0] s2_prod [LANES];
  logic                    s2_psat;
  logic signed [ACC_W-1:0] s2_psum;
  logic                    s2_mode;
  logic                    s2_last;
  logic                    s2_relu;

  state_t                  state;
  state_t                  state_nxt;
  logic signed [ACC_W-1:0] acc;
  logic                    sat_acc;

  logic signed [ACC_W-1:0] addend_c;
  logic                    emit_c;
  logic                    acc_upd_c;
  logic signed [SW-1:0]    sum_c;
  logic signed [ACC_W-1:0] clamp_c;
  logic                    ssat_c;
  logic                    grp_sat_c;
  logic signed [ACC_W-1:0] res_c;

  // Weight store; out-of-range lane writes are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) weight[i] <= '0;
    end else if (write_kernel && (int'(kernel_addr) < LANES)) begin
      weight[kernel_addr] <= kernel_data;
    end
  end

  // S1: capture the beat
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_ifmap <= '0;
      s1_psum  <= '0;
      s1_mode  <= 1'b0;
      s1_last  <= 1'b0;
      s1_relu  <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s1_ifmap <= ifmap_in;
      s1_psum  <= partial_sum_in;
      s1_mode  <= acc_mode;
      s1_last  <= in_last;
      s1_relu  <= relu_en;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [DATA_W-1:0] a;
    logic signed [PW-1:0]     p;
    logic signed [XW-1:0]     pe;
    assign a  = s1_ifmap[g*DATA_W +: DATA_W];
    assign p  = PW'(a) * PW'(weight[g]);
    assign pe = XW'(p);
    assign lane_hi[g] = pe > MAX_X;
    assign lane_lo[g] = pe < MIN_X;
    assign prod_c[g]  = lane_hi[g] ? ACC_MAX :
                        lane_lo[g] ? ACC_MIN : pe[ACC_W-1:0];
  end

  assign psat_c = |{lane_hi, lane_lo};

  // S2: register clamped lane products
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      for (int i = 0; i < LANES; i++) s2_prod[i] <= '0;
      s2_psat  <= 1'b0;
      s2_psum  <= '0;
      s2_mode  <= 1'b0;
      s2_last  <= 1'b0;
      s2_relu  <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      for (int i = 0; i < LANES; i++) s2_prod[i] <= prod_c[i];
      s2_psat  <= psat_c;
      s2_psum  <= s1_psum;
      s2_mode  <= s1_mode;
      s2_last  <= s1_last;
      s2_relu  <= s1_relu;
    end
  end

  // Group state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Group next-state: open on a non-last accumulate beat, close on last
  always_comb begin
    state_nxt = state;
    if (s2_valid) begin
      unique case (state)
        IDLE:  if (s2_mode && !s2_last) state_nxt = ACCUM;
        ACCUM: if (s2_last)             state_nxt = IDLE;
      endcase
    end
  end

  // Group outputs: addend select and emit/accumulate decision
  always_comb begin
    addend_c  = s2_psum;
    emit_c    = 1'b0;
    acc_upd_c = 1'b0;
    if (state == ACCUM) begin
      addend_c  = acc;
      emit_c    = s2_valid && s2_last;
      acc_upd_c = s2_valid && !s2_last;
    end else begin
      emit_c    = s2_valid && (!s2_mode || s2_last);
      acc_upd_c = s2_valid && s2_mode && !s2_last;
    end
  end

  // S3 reduction, clamp and ReLU
  always_comb begin
    sum_c = SW'(addend_c);
    for (int i = 0; i < LANES; i++) sum_c = sum_c + SW'(s2_prod[i]);
    ssat_c  = 1'b0;
    clamp_c = sum_c[ACC_W-1:0];
    if (sum_c > MAX_S) begin
      clamp_c = ACC_MAX;
      ssat_c  = 1'b1;
    end else if (sum_c < MIN_S) begin
      clamp_c = ACC_MIN;
      ssat_c  = 1'b1;
    end
    grp_sat_c = s2_psat | ssat_c | ((state == ACCUM) & sat_acc);
    res_c     = (s2_relu && clamp_c[ACC_W-1]) ? '0 : clamp_c;
  end

  // S3 registers: running accumulator and held result
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      sat_acc    <= 1'b0;
      out_valid  <= 1'b0;
      output_sum <= '0;
      out_sat    <= 1'b0;
    end else begin
      out_valid <= emit_c;
      if (acc_upd_c) begin
        acc     <= clamp_c;
        sat_acc <= grp_sat_c;
      end else if (emit_c) begin
        acc     <= '0;
        sat_acc <= 1'b0;
      end
      if (emit_c) begin
        output_sum <= res_c;
        out_sat    <= grp_sat_c;
      end
    end
  end

endmodule
